// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Purpose  : Execute-stage ALU. ADD/SUB/OR/AND complete in one cycle.
//            MUL runs as an iterative shift-add multiplier over WIDTH cycles,
//            during which new requests are refused (ready_o low).
// Ports    : clk_i      - clock, rising edge active
//            rst_i      - asynchronous reset, active low
//            ALUCtrl_i  - operation code (ADD/SUB/MUL/OR/AND, others = ADD)
//            data1_i    - operand A
//            data2_i    - operand B
//            valid_i    - request strobe, taken when ready_o is high
//            flush_i    - synchronous abort of any operation in flight
//            ready_o    - block is idle and can take a request
//            done_o     - one-cycle pulse, data_o/zero_o just updated
//            data_o     - registered result
//            zero_o     - registered result-is-zero flag
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             valid_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  // Shared ALU control encoding; 3'b101..3'b111 are undefined and run as ADD.
  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_mul = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_and = 3'b100;

  // Counter holds the number of completed multiply steps (0..WIDTH-1).
  localparam int            CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] r_mplier;  // multiplier, shifted right each step
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_done;

  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_step_acc;

  // Single-cycle datapath; ADD is the fall-through for every other code.
  always_comb begin
    w_alu_res = data1_i + data2_i;
    case (ALUCtrl_i)
      c_op_sub: w_alu_res = data1_i - data2_i;
      c_op_or:  w_alu_res = data1_i | data2_i;
      c_op_and: w_alu_res = data1_i & data2_i;
      default:  w_alu_res = data1_i + data2_i;
    endcase
  end

  // One shift-add step; only the low WIDTH bits of the product are kept.
  assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_data   <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      // done is a strobe: it only survives the edge that produced a result.
      r_done <= 1'b0;
      if (flush_i) begin
        // Abort wins over any request presented at the same edge.
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (valid_i) begin
              if (ALUCtrl_i == c_op_mul) begin
                r_mcand  <= data1_i;
                r_mplier <= data2_i;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_state  <= S_MUL;
              end else begin
                r_data <= w_alu_res;
                r_zero <= (w_alu_res == '0);
                r_done <= 1'b1;
              end
            end
          end
          S_MUL: begin
            r_acc    <= w_step_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == c_last) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_data  <= w_step_acc;
              r_zero  <= (w_step_acc == '0);
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign done_o  = r_done;
  assign data_o  = r_data;
  assign zero_o  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec
// Purpose  : Directed self-checking bench for alu_exec (WIDTH = 32).
//            Inputs change 1 time unit after a rising edge; outputs are
//            sampled at the same point, away from the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

  localparam int WIDTH = 32;

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_mul = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_and = 3'b100;
  localparam logic [2:0] c_op_bad = 3'b101;

  logic             clk;
  logic             rst_n;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             valid;
  logic             flush;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             zero;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .ALUCtrl_i (alu_ctrl),
    .data1_i   (data1),
    .data2_i   (data2),
    .valid_i   (valid),
    .flush_i   (flush),
    .ready_o   (ready),
    .done_o    (done),
    .data_o    (data_out),
    .zero_o    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = op;
    data1    = a;
    data2    = b;
    valid    = 1'b1;
  endtask

  int cnt_busy;
  int cnt_done;

  initial begin
    rst_n    = 1'b0;
    valid    = 1'b0;
    flush    = 1'b0;
    alu_ctrl = c_op_add;
    data1    = '0;
    data2    = '0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_data",  data_out,   32'h0);
    chk("reset_zero",  32'(zero),  32'd1);
    rst_n = 1'b1;   // released between edges
    tick();

    // ---------------- ADD 5+3 ----------------
    drive(c_op_add, 32'h5, 32'h3);
    tick();
    valid = 1'b0;
    chk("add_done",  32'(done),  32'd1);
    chk("add_data",  data_out,   32'h8);
    chk("add_zero",  32'(zero),  32'd0);
    chk("add_ready", 32'(ready), 32'd1);
    tick();
    chk("add_done_drop", 32'(done), 32'd0);
    chk("add_data_hold", data_out,  32'h8);

    // ---------------- SUB 7-7 then OR back-to-back ----------------
    drive(c_op_sub, 32'h7, 32'h7);
    tick();
    chk("sub_done", 32'(done), 32'd1);
    chk("sub_data", data_out,  32'h0);
    chk("sub_zero", 32'(zero), 32'd1);
    drive(c_op_or, 32'hF0F0F0F0, 32'h0F0F0F0F);
    tick();
    valid = 1'b0;
    chk("or_done", 32'(done), 32'd1);
    chk("or_data", data_out,  32'hFFFFFFFF);
    chk("or_zero", 32'(zero), 32'd0);
    tick();
    chk("or_done_drop", 32'(done), 32'd0);

    // ---------------- AND ----------------
    drive(c_op_and, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    tick();
    valid = 1'b0;
    chk("and_data", data_out, 32'h00F0_000F);
    tick();

    // ---------------- MUL 0x00010000 * 0x00010001 ----------------
    drive(c_op_mul, 32'h00010000, 32'h00010001);
    tick();   // edge k
    valid    = 1'b0;
    cnt_busy = 0;
    cnt_done = 0;
    for (int i = 0; i < 32; i++) begin
      if (!ready) cnt_busy++;
      if (done)   cnt_done++;
      tick();
    end
    // Now just after edge k+32.
    chk("mul_busy_cycles", 32'(cnt_busy), 32'd32);
    chk("mul_no_early_done", 32'(cnt_done), 32'd0);
    chk("mul_done",  32'(done),  32'd1);
    chk("mul_ready", 32'(ready), 32'd1);
    chk("mul_data",  data_out,   32'h00010000);
    chk("mul_zero",  32'(zero),  32'd0);
    tick();
    chk("mul_done_drop", 32'(done), 32'd0);

    // ---------------- ADD presented while MUL busy ----------------
    drive(c_op_mul, 32'h00001234, 32'h00000100);
    tick();   // edge k: MUL accepted
    drive(c_op_add, 32'd10, 32'd20);   // held until accepted
    cnt_done = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (done) cnt_done++;
    end
    chk("busy_add_ignored_done", 32'(cnt_done), 32'd0);
    chk("busy_add_ignored_data", data_out, 32'h00010000);
    tick();   // edge k+32
    chk("busy_mul_done", 32'(done), 32'd1);
    chk("busy_mul_data", data_out,  32'h00123400);
    chk("busy_mul_ready", 32'(ready), 32'd1);
    tick();   // held ADD now accepted
    valid = 1'b0;
    chk("readd_done", 32'(done), 32'd1);
    chk("readd_data", data_out,  32'd30);
    tick();

    // ---------------- flush at iteration 10 ----------------
    drive(c_op_mul, 32'd7, 32'd9);
    tick();   // edge k
    valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();   // edge k+10
    flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'd1);
    chk("flush_done",  32'(done),  32'd0);
    chk("flush_data",  data_out,   32'd30);
    cnt_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) cnt_done++;
    end
    chk("flush_no_done", 32'(cnt_done), 32'd0);
    chk("flush_data_hold", data_out, 32'd30);

    // ---------------- async reset mid-MUL ----------------
    drive(c_op_mul, 32'd3, 32'd4);
    tick();
    valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;   // between edges
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_done",  32'(done),  32'd0);
    chk("arst_data",  data_out,   32'h0);
    chk("arst_zero",  32'(zero),  32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) cnt_done++;
    end
    chk("arst_no_done", 32'(cnt_done), 32'd0);

    // ---------------- undefined code runs as ADD ----------------
    drive(c_op_bad, 32'd2, 32'd3);
    tick();
    valid = 1'b0;
    chk("undef_done", 32'(done), 32'd1);
    chk("undef_data", data_out,  32'd5);
    chk("undef_zero", 32'(zero), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The module SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port ALUCtrl_i, input, 3 bits: operation code, using the shared ALU control defines ADD, SUB, MUL, OR, AND.
REQ-005 The module SHALL have port data1_i, input, WIDTH bits: operand A (rs1).
REQ-006 The module SHALL have port data2_i, input, WIDTH bits: operand B (rs2 or immediate).
REQ-007 The module SHALL have port valid_i, input, 1 bit: request strobe; an operation is accepted on a rising edge where valid_i=1 and ready_o=1.
REQ-008 The module SHALL have port flush_i, input, 1 bit: synchronous abort of any operation in flight.
REQ-009 The module SHALL have port ready_o, output, 1 bit: the block can accept a request this cycle.
REQ-010 The module SHALL have port done_o, output, 1 bit: a one-cycle pulse marking data_o and zero_o valid.
REQ-011 The module SHALL have port data_o, output, WIDTH bits: registered result.
REQ-012 The module SHALL have port zero_o, output, 1 bit: registered flag, set when the result equals 0.

Function
REQ-013 The block SHALL implement two states, IDLE and MUL; ready_o SHALL be 1 exactly when the state is IDLE.
REQ-014 ADD SHALL compute data1_i+data2_i mod 2^WIDTH; SUB SHALL compute data1_i-data2_i mod 2^WIDTH; OR and AND SHALL be bitwise. No overflow or carry SHALL be reported.
REQ-015 Any ALUCtrl_i code other than ADD, SUB, MUL, OR or AND SHALL execute as ADD.
REQ-016 Single-cycle ops (ADD/SUB/OR/AND) accepted at edge k SHALL register data_o and zero_o at edge k, with done_o=1 for the cycle after edge k; the state SHALL stay IDLE, so back-to-back accepts are allowed, one result per cycle.
REQ-017 A MUL accepted at edge k SHALL latch both operands, clear a WIDTH-bit accumulator and an iteration counter, and enter MUL.
REQ-018 In MUL, each edge SHALL do one shift-add step on the multiplier LSB (add the shifted multiplicand to the accumulator if the LSB is 1, then shift).
REQ-019 MUL SHALL exit to IDLE on the edge that completes step WIDTH (edge k+WIDTH); at that edge data_o SHALL take the low WIDTH bits of the product and zero_o SHALL be set accordingly; done_o SHALL be 1 for the following cycle only.
REQ-020 valid_i while ready_o=0 SHALL be ignored, with no queuing; the requester SHALL hold the request until it sees ready_o=1.
REQ-021 data_o and zero_o SHALL hold their last values between done_o pulses, and SHALL change only on edges that produce a done_o.
REQ-022 flush_i=1 at an edge SHALL force IDLE, clear the counter and suppress any pending done_o; data_o and zero_o SHALL keep their values; flush_i SHALL take priority over valid_i at that edge.
REQ-023 After a flush, ready_o SHALL be 1 in the cycle following the flushing edge.
REQ-024 done_o SHALL never be asserted for two consecutive cycles as a result of one accepted request.

Reset
REQ-025 rst_i=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, accumulator=0, data_o=0, zero_o=1, done_o=0, ready_o=1.
REQ-026 Reset asserted during MUL SHALL abandon the operation with no done_o; after reset release, the first accepted request SHALL behave exactly as from power-up.
REQ-027 Release of rst_i SHALL be treated as synchronous to clk_i by the surrounding system; no request SHALL be accepted at the edge coincident with release.

Verification
REQ-028 The bench SHALL cover: reset, then ADD 0x00000005+0x00000003 -> done_o one cycle later, data_o=0x00000008, zero_o=0, ready_o stays 1.
REQ-029 The bench SHALL cover: SUB 7-7 followed on the next cycle by OR 0xF0F0F0F0|0x0F0F0F0F -> consecutive done_o pulses with data_o=0, zero_o=1, then 0xFFFFFFFF, zero_o=0.
REQ-030 The bench SHALL cover: MUL 0x00010000*0x00010001 (WIDTH=32) -> ready_o=0 for 32 cycles, done_o in the cycle after edge k+32, data_o=0x00010000.
REQ-031 The bench SHALL cover: a MUL in flight with a new valid_i ADD applied -> the ADD is ignored; the MUL result is delivered; the ADD, re-presented once ready_o=1, is accepted.
REQ-032 The bench SHALL cover: flush_i at iteration 10 of a MUL -> no done_o, ready_o=1 on the next cycle, data_o unchanged.
REQ-033 The bench SHALL cover: rst_i pulsed low mid-MUL between clock edges -> outputs go to reset values immediately, no done_o afterward; undefined code 3'b101 with operands 2,3 -> data_o=5.
